ex_mem_pipe: RTL and testbench
==============================

// Module: ex_mem_pipe
// PURPOSE
//  Parametrised EX->MEM pipeline register for the 5-stage core, successor to the fixed-width stage latch.
//  Adds a valid bit, synchronous flush, NOP-bubble insertion when EX stalls but MEM runs, and carry-through
//  of multi-cycle MADD/MSUB state (cnt, hilo_tempt) across bubbles, plus a saturating stall-cycle counter.
//  Sits between the EX stage / ctrl stall vector and the MEM stage; one clock, no combinational paths in->out.
// PARAMETERS
//  DATA_W    32  width of wdata, hi, lo; hilo_tempt is 2*DATA_W
//  ADDR_W    5   register-file write address width
//  CNT_W     5   multi-cycle op counter width
//  STALL_W   6   width of ctrl stall vector
//  STALL_BIT 4   stall-vector bit owning this stage (EX side uses STALL_BIT-1); must be >=1
//  PERF_W    16  stall-cycle counter width
// PORTS
//  clk             in   1          clock, rising edge
//  reset_n         in   1          asynchronous reset, active low
//  ex_mem_stall    in   STALL_W    ctrl stall vector
//  flush           in   1          synchronous flush (exception/eret), highest priority after reset
//  ex_valid        in   1          EX slot holds a real instruction
//  ex_we           in   1          GPR write enable
//  ex_waddr        in   ADDR_W     GPR write address
//  ex_wdata        in   DATA_W     GPR write data
//  ex_whilo        in   1          HI/LO write enable
//  ex_hi / ex_lo   in   DATA_W     HI / LO write data
//  ex_cnt          in   CNT_W      multi-cycle op step count
//  ex_hilo_tempt   in   2*DATA_W   multi-cycle partial product
//  mem_valid..mem_hilo_tempt out   registered copies of each ex_* input, same widths
//  mem_stall_cnt   out  PERF_W     cycles this stage has held (saturating)
// BEHAVIOUR
//  Reset (async, reset_n=0): every mem_* output and mem_stall_cnt = 0 immediately, independent of clk.
//  Per rising edge, first matching rule wins:
//   1 FLUSH   flush=1: all mem_* <= 0 incl. cnt and hilo_tempt; stall_cnt unchanged.
//   2 HOLD    stall[STALL_BIT]=1: all mem_* keep value; stall_cnt += 1, saturating at all-ones.
//   3 BUBBLE  stall[STALL_BIT-1]=1, stall[STALL_BIT]=0: mem_valid,we,whilo <= 0; waddr,wdata,hi,lo <= 0;
//             mem_cnt <= ex_cnt, mem_hilo_tempt <= ex_hilo_tempt (multi-cycle state survives the bubble).
//   4 CAPTURE otherwise: every mem_* <= matching ex_* input.
//  Latency: exactly 1 cycle EX->MEM on CAPTURE; no input reaches an output combinationally.
//  ex_valid=0 on CAPTURE: fields still copied; MEM qualifies we/whilo with mem_valid.
//  stall bits other than STALL_BIT and STALL_BIT-1 are ignored.
//  flush together with stall: flush wins; the slot is cleared even while held.
//  mem_stall_cnt: never wraps; cleared only by reset.
//  Reset asserted mid-operation: all state to 0, including a partially accumulated hilo_tempt.
// TESTING
//  T1 reset: drive all ex_* to nonzero, reset_n=0 -> all mem_*=0 before the next clk edge.
//  T2 capture: ex_we=1, waddr=5'd7, wdata=32'hDEADBEEF, stall=0 -> next cycle mem_*
//     matches the inputs and mem_valid=1.
//  T3 hold: load the T2 state, then stall=6'b011111 for 3 cycles with ex_wdata changing
//     -> mem_wdata stays 32'hDEADBEEF and mem_stall_cnt=3.
//  T4 bubble: stall=6'b001111, ex_cnt=2, ex_hilo_tempt=64'h1_0000_0001
//     -> mem_we=0, mem_wdata=0, mem_cnt=2, mem_hilo_tempt=64'h1_0000_0001.
//  T5 flush priority: flush=1 with stall=6'b011111 and nonzero mem_* -> all mem_* become 0 next cycle.
//  T6 saturation: PERF_W=4, hold for 20 cycles -> mem_stall_cnt=4'hF and stays there.

Source files
------------

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM slot payload: the EX stage drives it through the slave side,
// and the pipeline register republishes it to MEM through the master side.
interface ex_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 5
);
  logic                  valid;
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  whilo;
  logic [DATA_W-1:0]     hi;
  logic [DATA_W-1:0]     lo;
  logic [CNT_W-1:0]      cnt;
  logic [2*DATA_W-1:0]   hilo_tempt;

  modport master (
    output valid, we, waddr, wdata, whilo, hi, lo, cnt, hilo_tempt
  );

  modport slave (
    input  valid, we, waddr, wdata, whilo, hi, lo, cnt, hilo_tempt
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with flush, hold, NOP-bubble insertion that preserves
// multi-cycle MADD/MSUB state, and a saturating count of cycles spent held.
module ex_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 5,
  parameter int STALL_W   = 6,
  parameter int STALL_BIT = 4,
  parameter int PERF_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [STALL_W-1:0] ex_mem_stall,
  input  logic               flush,
  ex_mem_pipe_if.slave       ex,
  ex_mem_pipe_if.master      mem,
  output logic [PERF_W-1:0]  mem_stall_cnt
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  action_e               w_action;
  logic                  w_stallSat;

  logic                  r_valid;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_whilo;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_hiloTempt;
  logic [PERF_W-1:0]     r_stallCnt;

  // Flush beats hold, hold beats bubble; the EX-side stall only matters when MEM runs.
  always_comb begin
    w_action = ACT_CAPTURE;
    if (flush)
      w_action = ACT_FLUSH;
    else if (ex_mem_stall[STALL_BIT])
      w_action = ACT_HOLD;
    else if (ex_mem_stall[STALL_BIT-1])
      w_action = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_whilo     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_hiloTempt <= '0;
    end else begin
      unique case (w_action)
        ACT_FLUSH: begin
          r_valid     <= 1'b0;
          r_we        <= 1'b0;
          r_waddr     <= '0;
          r_wdata     <= '0;
          r_whilo     <= 1'b0;
          r_hi        <= '0;
          r_lo        <= '0;
          r_cnt       <= '0;
          r_hiloTempt <= '0;
        end
        ACT_HOLD: begin
        end
        // A bubble is a NOP, but the partial MADD/MSUB product must ride through it.
        ACT_BUBBLE: begin
          r_valid     <= 1'b0;
          r_we        <= 1'b0;
          r_waddr     <= '0;
          r_wdata     <= '0;
          r_whilo     <= 1'b0;
          r_hi        <= '0;
          r_lo        <= '0;
          r_cnt       <= ex.cnt;
          r_hiloTempt <= ex.hilo_tempt;
        end
        default: begin
          r_valid     <= ex.valid;
          r_we        <= ex.we;
          r_waddr     <= ex.waddr;
          r_wdata     <= ex.wdata;
          r_whilo     <= ex.whilo;
          r_hi        <= ex.hi;
          r_lo        <= ex.lo;
          r_cnt       <= ex.cnt;
          r_hiloTempt <= ex.hilo_tempt;
        end
      endcase
    end
  end

  assign w_stallSat = &r_stallCnt;

  // Counts held cycles only; a flush during a stall is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stallCnt <= '0;
    else if (w_action == ACT_HOLD && !w_stallSat)
      r_stallCnt <= r_stallCnt + 1'b1;
  end

  assign mem.valid      = r_valid;
  assign mem.we         = r_we;
  assign mem.waddr      = r_waddr;
  assign mem.wdata      = r_wdata;
  assign mem.whilo      = r_whilo;
  assign mem.hi         = r_hi;
  assign mem.lo         = r_lo;
  assign mem.cnt        = r_cnt;
  assign mem.hilo_tempt = r_hiloTempt;
  assign mem_stall_cnt  = r_stallCnt;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Random and directed checks of ex_mem_pipe against a slot-level reference model;
// a second instance with a 4-bit stall counter exercises saturation.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  cnt;
    logic [63:0] tempt;
  } slot_t;

  logic        clk;
  logic        reset_n;
  logic [5:0]  stall;
  logic        flush;
  slot_t       inSlot;
  logic [15:0] stallCnt;
  logic [3:0]  stallCntSat;
  slot_t       memSlot;
  slot_t       memSlotSat;

  slot_t       expSlot;
  int          expCnt;
  int          expCntSat;
  int          errors;
  int          checks;
  bit          cmpEn;

  ex_mem_pipe_if exIf ();
  ex_mem_pipe_if memIf ();
  ex_mem_pipe_if exIfSat ();
  ex_mem_pipe_if memIfSat ();

  ex_mem_pipe dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_mem_stall (stall),
    .flush        (flush),
    .ex           (exIf),
    .mem          (memIf),
    .mem_stall_cnt(stallCnt)
  );

  ex_mem_pipe #(.PERF_W(4)) dutSat (
    .clk          (clk),
    .reset_n      (reset_n),
    .ex_mem_stall (stall),
    .flush        (flush),
    .ex           (exIfSat),
    .mem          (memIfSat),
    .mem_stall_cnt(stallCntSat)
  );

  assign {exIf.valid, exIf.we, exIf.waddr, exIf.wdata, exIf.whilo,
          exIf.hi, exIf.lo, exIf.cnt, exIf.hilo_tempt} = inSlot;
  assign {exIfSat.valid, exIfSat.we, exIfSat.waddr, exIfSat.wdata, exIfSat.whilo,
          exIfSat.hi, exIfSat.lo, exIfSat.cnt, exIfSat.hilo_tempt} = inSlot;
  assign memSlot = {memIf.valid, memIf.we, memIf.waddr, memIf.wdata, memIf.whilo,
                    memIf.hi, memIf.lo, memIf.cnt, memIf.hilo_tempt};
  assign memSlotSat = {memIfSat.valid, memIfSat.we, memIfSat.waddr, memIfSat.wdata,
                       memIfSat.whilo, memIfSat.hi, memIfSat.lo, memIfSat.cnt,
                       memIfSat.hilo_tempt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the MEM slot must hold after each edge.
  always @(posedge clk or negedge reset_n) begin
    slot_t bubble;
    if (!reset_n) begin
      expSlot   = '0;
      expCnt    = 0;
      expCntSat = 0;
    end else if (flush) begin
      expSlot = '0;
    end else if (stall[4]) begin
      expCnt    = (expCnt + 1 > 65535) ? 65535 : expCnt + 1;
      expCntSat = (expCntSat + 1 > 15) ? 15 : expCntSat + 1;
    end else if (stall[3]) begin
      bubble       = '0;
      bubble.cnt   = inSlot.cnt;
      bubble.tempt = inSlot.tempt;
      expSlot      = bubble;
    end else begin
      expSlot = inSlot;
    end
  end

  task automatic checkOutput(input string name, input logic [191:0] act,
                             input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input slot_t s, input logic [5:0] st, input logic fl);
    inSlot = s;
    stall  = st;
    flush  = fl;
  endtask

  function automatic slot_t randSlot();
    slot_t s;
    s.valid = 1'($urandom);
    s.we    = 1'($urandom);
    s.waddr = 5'($urandom);
    s.wdata = $urandom;
    s.whilo = 1'($urandom);
    s.hi    = $urandom;
    s.lo    = $urandom;
    s.cnt   = 5'($urandom);
    s.tempt = {$urandom, $urandom};
    return s;
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model slot", memSlot, expSlot);
      checkOutput("model slot sat", memSlotSat, expSlot);
      checkOutput("model stall_cnt", stallCnt, expCnt[15:0]);
      checkOutput("model stall_cnt sat", stallCntSat, expCntSat[3:0]);
    end
  end

  initial begin
    slot_t s;
    logic [5:0] st;
    errors  = 0;
    checks  = 0;
    cmpEn   = 1'b0;
    reset_n = 1'b1;
    s       = '1;
    applyStimulus(s, 6'b000000, 1'b0);

    // T1: capture nonzero data, then async reset must clear before the next edge
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("T1 reset slot", memSlot, '0);
    checkOutput("T1 reset slot sat", memSlotSat, '0);
    checkOutput("T1 reset stall_cnt", stallCnt, '0);
    @(negedge clk);
    reset_n = 1'b1;
    cmpEn   = 1'b1;

    // T2: capture
    s = '0;
    s.valid = 1'b1;
    s.we    = 1'b1;
    s.waddr = 5'd7;
    s.wdata = 32'hDEADBEEF;
    applyStimulus(s, 6'b000000, 1'b0);
    @(negedge clk);
    checkOutput("T2 wdata", memIf.wdata, 32'hDEADBEEF);
    checkOutput("T2 waddr/we/valid", {memIf.waddr, memIf.we, memIf.valid}, {5'd7, 1'b1, 1'b1});

    // T3: hold three cycles with changing input data
    for (int i = 0; i < 3; i++) begin
      s.wdata = $urandom;
      applyStimulus(s, 6'b011111, 1'b0);
      @(negedge clk);
    end
    checkOutput("T3 held wdata", memIf.wdata, 32'hDEADBEEF);
    checkOutput("T3 stall_cnt", stallCnt, 16'd3);

    // T4: bubble keeps multi-cycle state only
    s = '0;
    s.valid = 1'b1;
    s.we    = 1'b1;
    s.wdata = 32'h1234_5678;
    s.cnt   = 5'd2;
    s.tempt = 64'h1_0000_0001;
    applyStimulus(s, 6'b001111, 1'b0);
    @(negedge clk);
    checkOutput("T4 we/wdata/valid", {memIf.we, memIf.wdata, memIf.valid}, '0);
    checkOutput("T4 cnt", memIf.cnt, 5'd2);
    checkOutput("T4 hilo_tempt", memIf.hilo_tempt, 64'h1_0000_0001);

    // T5: flush wins over hold and leaves the counter alone
    s = randSlot();
    s.valid = 1'b1;
    s.wdata = 32'hCAFE_F00D;
    applyStimulus(s, 6'b000000, 1'b0);
    @(negedge clk);
    applyStimulus(randSlot(), 6'b011111, 1'b1);
    @(negedge clk);
    checkOutput("T5 flushed slot", memSlot, '0);
    checkOutput("T5 stall_cnt kept", stallCnt, 16'd3);

    // T6: 4-bit counter saturates and stays
    for (int i = 0; i < 20; i++) begin
      applyStimulus(randSlot(), 6'b010000, 1'b0);
      @(negedge clk);
    end
    checkOutput("T6 saturated", stallCntSat, 4'hF);
    checkOutput("T6 wide counter", stallCnt, 16'd23);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(randSlot(), 6'b110000, 1'b0);
      @(negedge clk);
    end
    checkOutput("T6 stays saturated", stallCntSat, 4'hF);

    // Random phase including occasional mid-operation resets
    for (int i = 0; i < 2000; i++) begin
      st = 6'($urandom);
      if ($urandom_range(0, 2) == 0)
        st[4] = 1'b0;
      applyStimulus(randSlot(), st, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      @(negedge clk);
    end

    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
